// File: rtl/stream_delay_pkg.sv
// stream_delay_pkg
// Shared constants and helpers for the stream_delay fixed-latency delay line.
//   MAX_CLK_DEL : largest supported number of pipeline stages.
//   occ_width() : bit width needed to count 0..depth occupied stages.
package stream_delay_pkg;

  localparam int MAX_CLK_DEL = 64;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_delay_stage.sv
// stream_delay_stage
// One stage of the stream_delay line: a valid flag plus a data word.
// Ports:
//   clk     : posedge clock
//   rst_n   : asynchronous active-low reset, clears valid and data
//   adv     : stage may take the previous stage's contents this cycle
//   prev_v  : valid flag offered by the previous stage (or the input)
//   prev_d  : data word offered by the previous stage (or the input)
//   v, d    : registered valid flag and data of this stage
module stream_delay_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         prev_v,
  input  logic [W-1:0] prev_d,
  output logic         v,
  output logic [W-1:0] d
);

  // Data loads even when the incoming flag is invalid; it is ignored while v = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else if (adv) begin
      v <= prev_v;
      d <= prev_d;
    end
  end

endmodule

// File: rtl/stream_delay.sv
// stream_delay
// Fixed-latency delay line for a valid/ready stream. CLK_DEL stages give an
// unstalled latency of CLK_DEL cycles and a capacity of CLK_DEL words; empty
// stages always advance so bubbles collapse behind a stalled output word.
// Parameters:
//   W        : data width
//   CLK_DEL  : number of stages, 1..MAX_CLK_DEL
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data is the accepted word
//   out_valid/out_ready  : downstream handshake, out_data is the delayed word
//   occupancy            : number of valid stages (only with STREAM_DELAY_OCC_EN)
// Optional feature macro: STREAM_DELAY_OCC_EN adds the occupancy counter.
module stream_delay
  import stream_delay_pkg::*;
#(
  parameter int W       = 8,
  parameter int CLK_DEL = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data
`ifdef STREAM_DELAY_OCC_EN
  ,
  output logic [occ_width(CLK_DEL)-1:0] occupancy
`endif
);

  if (CLK_DEL < 1 || CLK_DEL > MAX_CLK_DEL) begin : g_bad_clk_del
    $error("stream_delay: CLK_DEL must be in 1..64");
  end

  logic [CLK_DEL-1:0] v;
  logic [CLK_DEL-1:0] adv;
  logic [CLK_DEL-1:0] prev_v;
  logic [W-1:0]       d      [CLK_DEL];
  logic [W-1:0]       prev_d [CLK_DEL];

  // Advance chain evaluated from the output backwards: a stage moves if it is
  // empty or everything downstream of it is moving. A running carry keeps the
  // chain free of self-referencing vector bits.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = !v[CLK_DEL-1] || out_ready;
    adv[CLK_DEL-1] = carry;
    for (int i = CLK_DEL - 2; i >= 0; i--) begin
      carry  = !v[i] || carry;
      adv[i] = carry;
    end
  end

  for (genvar i = 0; i < CLK_DEL; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign prev_v[i] = in_valid;
      assign prev_d[i] = in_data;
    end else begin : g_rest
      assign prev_v[i] = v[i-1];
      assign prev_d[i] = d[i-1];
    end

    stream_delay_stage #(
      .W(W)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv[i]),
      .prev_v(prev_v[i]),
      .prev_d(prev_d[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[CLK_DEL-1];
  assign out_data  = d[CLK_DEL-1];

`ifdef STREAM_DELAY_OCC_EN
  localparam int OW = occ_width(CLK_DEL);

  logic accept;
  logic handoff;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  // Simultaneous accept and hand-off leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (accept && !handoff) begin
      occupancy <= occupancy + OW'(1);
    end else if (!accept && handoff) begin
      occupancy <= occupancy - OW'(1);
    end
  end

  occ_matches_valid_flags : assert property (
    @(posedge clk) disable iff (!rst_n) occupancy == OW'($countones(v))
  );
`endif

endmodule

// File: tb/tb_stream_delay.sv
// tb_stream_delay
// Self-checking bench for stream_delay with W=8, CLK_DEL=4. Accepted words are
// pushed into a scoreboard queue by the driver; a monitor pops and compares on
// every output handshake and checks in_ready against a word-count model.
module tb_stream_delay;

  localparam int W       = 8;
  localparam int CLK_DEL = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef STREAM_DELAY_OCC_EN
  logic [$clog2(CLK_DEL+1)-1:0] occupancy;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sb[$];
  int           pop_log[$];
  int           cyc = 0;
  int           in_flight = 0;
  bit           hold_prev = 0;
  logic [W-1:0] held_data = '0;

  stream_delay #(
    .W      (W),
    .CLK_DEL(CLK_DEL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef STREAM_DELAY_OCC_EN
    ,
    .occupancy(occupancy)
`endif
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of input starting just after a posedge; records the word
  // in the scoreboard if it was accepted at the coming edge.
  task automatic applyStimulus(input logic valid, input logic [W-1:0] data,
                               output bit accepted);
    in_valid = valid;
    in_data  = data;
    @(negedge clk);
    accepted = rst_n && in_valid && in_ready;
    if (accepted) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    bit acc;
    n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      applyStimulus(1'b0, '0, acc);
      n++;
    end
    if (n >= 60) checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: reference model is simply "words in flight"; the line is full
  // exactly when it holds CLK_DEL words, and output order is FIFO order.
  always @(negedge clk) begin
    bit exp_ready;
    logic [W-1:0] exp_word;
    cyc++;
    if (!rst_n) begin
      in_flight = 0;
      hold_prev = 0;
    end else begin
      exp_ready = !(in_flight == CLK_DEL && !out_ready);
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
`ifdef STREAM_DELAY_OCC_EN
      checkOutput("occupancy", 32'(occupancy), 32'(in_flight));
`endif
      if (hold_prev) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(held_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_output: got word %0h expected no word at time %0t",
                   out_data, $time);
        end else begin
          exp_word = sb.pop_front();
          checkOutput("out_data", 32'(out_data), 32'(exp_word));
        end
        pop_log.push_back(cyc);
      end
      if (in_valid && in_ready) in_flight++;
      if (out_valid && out_ready) in_flight--;
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  initial begin
    bit acc;
    int cycles;
    logic [W-1:0] first_word;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset checks");
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
`ifdef STREAM_DELAY_OCC_EN
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    // First word latency with out_ready held high.
    $display("[TB] latency");
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h11, acc);
    checkOutput("latency_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 12) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency_cycles", 32'(cycles), 32'(CLK_DEL));
    checkOutput("latency_data", 32'(out_data), 32'h11);
    drain("latency");

    // Back-to-back streaming, one word per cycle, no gaps.
    $display("[TB] streaming");
    pop_log.delete();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, W'(i), acc);
      checkOutput("stream_accept", 32'(acc), 32'd1);
    end
    drain("stream");
    checkOutput("stream_count", 32'(pop_log.size()), 32'd16);
    if (pop_log.size() == 16)
      checkOutput("stream_no_gaps", 32'(pop_log[15] - pop_log[0]), 32'd15);

    // Fill then stall.
    $display("[TB] fill and stall");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, W'(8'hA0 + i), acc);
      checkOutput("fill_accept", 32'(acc), 32'd1);
    end
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_out_data", 32'(out_data), 32'hA0);
`ifdef STREAM_DELAY_OCC_EN
    checkOutput("full_occupancy", 32'(occupancy), 32'd4);
`endif
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'hA4, acc);
      checkOutput("full_reject", 32'(acc), 32'd0);
      checkOutput("full_hold_data", 32'(out_data), 32'hA0);
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'hA4, acc);
    out_ready = 1'b0;
    checkOutput("swap_accept", 32'(acc), 32'd1);
    checkOutput("swap_next_data", 32'(out_data), 32'hA1);
`ifdef STREAM_DELAY_OCC_EN
    checkOutput("swap_occupancy", 32'(occupancy), 32'd4);
`endif
    applyStimulus(1'b1, 8'hA5, acc);
    checkOutput("refull_reject", 32'(acc), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'hA5, acc);
    checkOutput("a5_accept", 32'(acc), 32'd1);
    drain("fill");
`ifdef STREAM_DELAY_OCC_EN
    checkOutput("drained_occupancy", 32'(occupancy), 32'd0);
`endif

    // Bubble collapse behind a stalled word.
    $display("[TB] bubble collapse");
    pop_log.delete();
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h05, acc);
    applyStimulus(1'b0, 8'h00, acc);
    applyStimulus(1'b0, 8'h00, acc);
    applyStimulus(1'b1, 8'h06, acc);
    applyStimulus(1'b0, 8'h00, acc);
    applyStimulus(1'b0, 8'h00, acc);
    drain("bubble");
    checkOutput("bubble_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2)
      checkOutput("bubble_consecutive", 32'(pop_log[1] - pop_log[0]), 32'd1);

    // Asynchronous reset with words in flight.
    $display("[TB] mid-flight reset");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, W'(8'hC0 + i), acc);
    end
    applyStimulus(1'b0, 8'h00, acc);
    first_word = 8'hC0;
    checkOutput("inflight_out_valid", 32'(out_valid), 32'd1);
    checkOutput("inflight_out_data", 32'(out_data), 32'(first_word));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_data", 32'(out_data), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pop_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, acc);
    end
    checkOutput("no_stale_words", 32'(pop_log.size()), 32'd0);
    checkOutput("post_reset_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), acc);
    end
    drain("random");
    checkOutput("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_delay.md
Name: stream_delay

Overview:
- Fixed-latency delay line for a valid/ready stream, with backpressure.
- Each stage holds a data word and a valid flag. Bubbles collapse, and the line stalls only when it is completely full.
- Used where a pipelined video/pixel path must stay aligned with side data but the downstream consumer can stall.
- Unstalled latency equals the plain register delay of CLK_DEL cycles.

Parameters:
- W, 8, bit width of the transported data.
- CLK_DEL, 1, number of pipeline stages; this is both the unstalled latency and the capacity in words. Legal range is 1 to 64; a value of 0 is a compile-time error.

Ports:
- clk  in  1  posedge-active clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stream_delay can accept this cycle.
- in_data  in  W  data to be delayed.
- out_valid  out  1  out_data holds a valid delayed word.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  W  delayed data.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n = 0: every stage's valid = 0 and data = 0, so out_valid = 0 and out_data = 0.
  - in_ready = 1 from the first cycle after reset release.
- Stages are numbered 0 (input) to CLK_DEL-1 (output).
  - v[i] and d[i] are the valid flag and data of stage i.
  - out_valid = v[CLK_DEL-1] and out_data = d[CLK_DEL-1], both driven directly from registers.
- Advance rule (combinational, evaluated from the output backwards):
  - adv[CLK_DEL-1] = !v[CLK_DEL-1] || out_ready.
  - adv[i] = !v[i] || adv[i+1].
  - in_ready = adv[0].
- Register update on posedge clk:
  - Stage 0: if adv[0], then v[0] <= in_valid and d[0] <= in_data; otherwise it holds.
  - Stage i > 0: if adv[i], then v[i] <= v[i-1] and d[i] <= d[i-1]; otherwise it holds.
  - When a stage loads an invalid word, its data register still loads. Data is don't-care when v = 0 and must not be checked.
- Latency:
  - A word accepted at edge k (in_valid && in_ready) is presented on out_data from edge k+CLK_DEL-1 onward, i.e. CLK_DEL cycles after in_valid was first seen, when no stall occurs.
  - Stalls add latency only; order is always preserved.
- Bubbles: an empty stage always advances, so gaps in the input are squeezed out behind a stalled output word.
- Full condition: all v = 1 and out_ready = 0, giving in_ready = 0.
  - Transfers are simultaneous: when full and out_ready = 1, in_ready = 1 and one word enters while one leaves in the same cycle. Throughput stays at 1 word per cycle.
- Handshake rules:
  - out_valid never drops without an out_ready handshake.
  - out_data is stable while out_valid && !out_ready.
  - in_ready may depend combinationally on out_ready. The path is O(CLK_DEL) long, which is accepted.
- Reset mid-operation: all in-flight words are discarded immediately and asynchronously; there is no flush handshake.
- CLK_DEL = 1: a single stage, equivalent to a one-entry pipe register with backpressure.

Optional Feature:
- Macro: STREAM_DELAY_OCC_EN.
- When defined:
  - Adds output port occupancy, width $clog2(CLK_DEL+1), reporting the number of set v flags.
  - It is a registered counter: +1 on accept only, -1 on output handshake only, unchanged when both or neither occur.
  - Reset value is 0.
  - An assertion checks that the counter always equals the population count of the valid flags.
- When undefined: the port is absent and there is no counter logic.

Decomposition:
- Package stream_delay_pkg:
  - Localparam MAX_CLK_DEL = 64.
  - A function occ_width(depth) returning $clog2(depth+1).
- Sub-module stream_delay_stage (parameter W): one stage.
  - Inputs: adv, prev_v, prev_d.
  - Outputs: v, d.
  - Uses the same clk/rst_n.
- stream_delay instantiates the stages in a generate loop, and the adv chain lives in the top module.

Test Plan:
- Reset release, W=8, CLK_DEL=4:
  - Apply in_valid = 1 with 0x11 and out_ready = 1 held high.
  - Required: out_valid rises 4 cycles later with 0x11.
  - Required: in_ready = 1 throughout.
- Streaming 0x01..0x10 back-to-back with out_ready = 1:
  - Required: the outputs appear in order with 1 word per cycle and no gaps.
- Fill then stall:
  - Hold out_ready = 0 and send 0xA0..0xA5.
  - Required: in_ready falls after 4 accepts; 0xA0 holds stable on out_data; 0xA4 is held upstream.
  - Then raise out_ready for 1 cycle. Required: 0xA0 leaves, 0xA4 enters the same cycle, and in_ready stays 1.
- Bubble collapse:
  - Send 0x05, idle 2 cycles, send 0x06, with out_ready = 0 for 6 cycles.
  - Required: on release, 0x05 and 0x06 emerge on consecutive cycles.
- Assert rst_n = 0 asynchronously while 3 words are in flight:
  - Required: out_valid = 0 and out_data = 0 before the next clk edge.
  - Required: no stale words appear after release.
- With STREAM_DELAY_OCC_EN, in the fill/stall case:
  - Required: occupancy goes 0→4, stays 4 during simultaneous in/out, and returns to 0 after draining.
